// File: rtl/vga_pkg.sv
// Shared VGA timing constants, colour tuple and axis phase type.
// Default constants describe 640x480 @ 60 Hz.
package vga_pkg;

  localparam int H_ACTIVE_D = 640;
  localparam int H_FP_D     = 16;
  localparam int H_SYNC_D   = 96;
  localparam int H_BP_D     = 48;
  localparam int V_ACTIVE_D = 480;
  localparam int V_FP_D     = 10;
  localparam int V_SYNC_D   = 2;
  localparam int V_BP_D     = 33;
  localparam int COLOR_W_D  = 1;
  localparam int CNT_W_D    = 10;

  typedef struct packed {
    logic [COLOR_W_D-1:0] r;
    logic [COLOR_W_D-1:0] g;
    logic [COLOR_W_D-1:0] b;
  } rgb_t;

  typedef enum logic [1:0] {
    PH_ACTIVE,
    PH_FP,
    PH_SYNC,
    PH_BP
  } phase_t;

  function automatic int axis_total(
    input int act, input int fp, input int sw, input int bp
  );
    return act + fp + sw + bp;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: wrapping counter, phase decode and sync level.
// Used once per line (H) and once per frame (V).
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int ACTIVE = H_ACTIVE_D,
  parameter int FP     = H_FP_D,
  parameter int SYNC   = H_SYNC_D,
  parameter int BP     = H_BP_D,
  parameter bit POL    = 1'b1,
  parameter int CNT_W  = CNT_W_D
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_wrap,
  output logic             o_active,
  output logic             o_sync
);

  localparam int TOTAL   = axis_total(ACTIVE, FP, SYNC, BP);
  localparam int SYNC_LO = ACTIVE + FP;
  localparam int SYNC_HI = SYNC_LO + SYNC;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL - 1);

  generate
    if (longint'(TOTAL) > (longint'(1) << CNT_W)) begin : g_range_chk
      $error("vga_axis_counter: total does not fit in CNT_W");
    end
  endgenerate

  logic [CNT_W-1:0] r_cnt;
  logic             w_last;
  phase_t           w_phase;

  assign w_last = (r_cnt == LAST);

  // Advance one position per enable, wrapping after the last one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_last ? '0 : r_cnt + 1'b1;
    end
  end

  // Decode which part of the axis the counter is in.
  always_comb begin
    w_phase = PH_BP;
    if (int'(r_cnt) < ACTIVE) begin
      w_phase = PH_ACTIVE;
    end else if (int'(r_cnt) < SYNC_LO) begin
      w_phase = PH_FP;
    end else if (int'(r_cnt) < SYNC_HI) begin
      w_phase = PH_SYNC;
    end
  end

  assign o_cnt    = r_cnt;
  assign o_wrap   = i_en && w_last;
  assign o_active = (w_phase == PH_ACTIVE);
  assign o_sync   = (w_phase == PH_SYNC) ? POL : ~POL;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing with a single-rectangle fg/bg window overlay.
// All outputs are registered one pix_ce after the counter state.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_D,
  parameter int H_FP     = H_FP_D,
  parameter int H_SYNC   = H_SYNC_D,
  parameter int H_BP     = H_BP_D,
  parameter int V_ACTIVE = V_ACTIVE_D,
  parameter int V_FP     = V_FP_D,
  parameter int V_SYNC   = V_SYNC_D,
  parameter int V_BP     = V_BP_D,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1,
  parameter int COLOR_W  = COLOR_W_D,
  parameter int CNT_W    = CNT_W_D
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pix_ce,
  input  logic [CNT_W-1:0]   win_x0,
  input  logic [CNT_W-1:0]   win_x1,
  input  logic [CNT_W-1:0]   win_y0,
  input  logic [CNT_W-1:0]   win_y1,
  input  logic [3*COLOR_W-1:0] fg_color,
  input  logic [3*COLOR_W-1:0] bg_color,
  output logic [COLOR_W-1:0] R,
  output logic [COLOR_W-1:0] G,
  output logic [COLOR_W-1:0] B,
  output logic               h_sync,
  output logic               v_sync,
  output logic               de,
  output logic [CNT_W-1:0]   x,
  output logic [CNT_W-1:0]   y,
  output logic               frame_start,
  output logic               line_start
);

  localparam int CW = 3 * COLOR_W;

  logic [CNT_W-1:0] w_h_cnt, w_v_cnt;
  logic             w_h_wrap, w_v_wrap_unused;
  logic             w_h_act, w_v_act;
  logic             w_h_sync, w_v_sync;

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP),
    .POL(HS_POL), .CNT_W(CNT_W)
  ) u_h (
    .clk(clk), .rst(rst), .i_en(pix_ce),
    .o_cnt(w_h_cnt), .o_wrap(w_h_wrap),
    .o_active(w_h_act), .o_sync(w_h_sync)
  );

  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP),
    .POL(VS_POL), .CNT_W(CNT_W)
  ) u_v (
    .clk(clk), .rst(rst), .i_en(w_h_wrap),
    .o_cnt(w_v_cnt), .o_wrap(w_v_wrap_unused),
    .o_active(w_v_act), .o_sync(w_v_sync)
  );

  logic [CNT_W-1:0] r_sh_x0, r_sh_x1, r_sh_y0, r_sh_y1;
  logic [CW-1:0]    r_sh_fg, r_sh_bg;
  logic             w_top;
  logic [CNT_W-1:0] w_x0, w_x1, w_y0, w_y1;
  logic [CW-1:0]    w_fg, w_bg, w_rgb;
  logic             w_de, w_inside;

  assign w_top = (w_h_cnt == '0) && (w_v_cnt == '0);

  // Pixel (0,0) already sees the values being latched for the new frame.
  assign w_x0 = w_top ? win_x0 : r_sh_x0;
  assign w_x1 = w_top ? win_x1 : r_sh_x1;
  assign w_y0 = w_top ? win_y0 : r_sh_y0;
  assign w_y1 = w_top ? win_y1 : r_sh_y1;
  assign w_fg = w_top ? fg_color : r_sh_fg;
  assign w_bg = w_top ? bg_color : r_sh_bg;

  assign w_de     = w_h_act && w_v_act;
  assign w_inside = (w_h_cnt >= w_x0) && (w_h_cnt < w_x1) &&
                    (w_v_cnt >= w_y0) && (w_v_cnt < w_y1);
  assign w_rgb    = !w_de ? '0 : (w_inside ? w_fg : w_bg);

  // Latch window and colours once per frame at the top-left pixel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sh_x0 <= '0;
      r_sh_x1 <= '0;
      r_sh_y0 <= '0;
      r_sh_y1 <= '0;
      r_sh_fg <= '0;
      r_sh_bg <= '0;
    end else if (pix_ce && w_top) begin
      r_sh_x0 <= win_x0;
      r_sh_x1 <= win_x1;
      r_sh_y0 <= win_y0;
      r_sh_y1 <= win_y1;
      r_sh_fg <= fg_color;
      r_sh_bg <= bg_color;
    end
  end

  logic [CW-1:0]    r_rgb;
  logic             r_hs, r_vs, r_de, r_fs, r_ls;
  logic [CNT_W-1:0] r_x, r_y;

  // Register every output from the current counter state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rgb <= '0;
      r_hs  <= ~HS_POL;
      r_vs  <= ~VS_POL;
      r_de  <= 1'b0;
      r_x   <= '0;
      r_y   <= '0;
      r_fs  <= 1'b0;
      r_ls  <= 1'b0;
    end else if (pix_ce) begin
      r_rgb <= w_rgb;
      r_hs  <= w_h_sync;
      r_vs  <= w_v_sync;
      r_de  <= w_de;
      r_x   <= w_de ? w_h_cnt : '0;
      r_y   <= w_de ? w_v_cnt : '0;
      r_fs  <= w_top;
      r_ls  <= (w_h_cnt == '0) && w_v_act;
    end
  end

  assign R           = r_rgb[CW-1 -: COLOR_W];
  assign G           = r_rgb[2*COLOR_W-1 -: COLOR_W];
  assign B           = r_rgb[COLOR_W-1:0];
  assign h_sync      = r_hs;
  assign v_sync      = r_vs;
  assign de          = r_de;
  assign x           = r_x;
  assign y           = r_y;
  assign frame_start = r_fs;
  assign line_start  = r_ls;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on a reduced raster.
// Driver pushes expected pixels; monitor pops and compares.
module tb_vga_timing_gen;
  import vga_pkg::*;

  localparam int HA = 16, HF = 2, HSW = 3, HB = 3, HT = 24;
  localparam int VA = 10, VF = 2, VSW = 2, VB = 3, VT = 17;
  localparam int FR = HT * VT;
  localparam bit HP = 1'b0;
  localparam bit VP = 1'b1;

  typedef struct packed {
    rgb_t       c;
    logic       hs;
    logic       vs;
    logic       de;
    logic [9:0] x;
    logic [9:0] y;
    logic       fs;
    logic       ls;
  } out_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic pix_ce = 1'b0;
  logic [9:0] win_x0 = '0, win_x1 = '0, win_y0 = '0, win_y1 = '0;
  logic [2:0] fg_color = '0, bg_color = '0;
  logic R, G, B, h_sync, v_sync, de, frame_start, line_start;
  logic [9:0] x, y;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
    .HS_POL(HP), .VS_POL(VP), .COLOR_W(1), .CNT_W(10)
  ) dut (
    .clk(clk), .rst(rst), .pix_ce(pix_ce),
    .win_x0(win_x0), .win_x1(win_x1),
    .win_y0(win_y0), .win_y1(win_y1),
    .fg_color(fg_color), .bg_color(bg_color),
    .R(R), .G(G), .B(B),
    .h_sync(h_sync), .v_sync(v_sync), .de(de),
    .x(x), .y(y),
    .frame_start(frame_start), .line_start(line_start)
  );

  always #5 clk = ~clk;

  out_t q[$];
  out_t last, mon_e, mon_g;
  int checks = 0, failures = 0;
  int n_de, n_white, n_hs, n_vs, n_fs, n_ls, n_col, n_bad;
  int mh = 0, mv = 0;
  logic [9:0] sx0 = '0, sx1 = '0, sy0 = '0, sy1 = '0;
  logic [2:0] sfg = '0, sbg = '0;
  logic mon_ce, mon_rst;

  function automatic out_t dut_out();
    out_t o;
    o.c.r = R; o.c.g = G; o.c.b = B;
    o.hs = h_sync; o.vs = v_sync; o.de = de;
    o.x = x; o.y = y;
    o.fs = frame_start; o.ls = line_start;
    return o;
  endfunction

  function automatic out_t rst_val();
    out_t o;
    o = '0;
    o.hs = ~HP;
    o.vs = ~VP;
    return o;
  endfunction

  function automatic out_t expect_px(
    input int h, input int v,
    input logic [9:0] x0, input logic [9:0] x1,
    input logic [9:0] y0, input logic [9:0] y1,
    input logic [2:0] fg, input logic [2:0] bg
  );
    out_t o;
    logic ins;
    o = '0;
    o.de = (h < HA) && (v < VA);
    ins = (h >= int'(x0)) && (h < int'(x1)) &&
          (v >= int'(y0)) && (v < int'(y1));
    if (o.de) o.c = rgb_t'(ins ? fg : bg);
    o.hs = (h >= HA + HF && h < HA + HF + HSW) ? HP : ~HP;
    o.vs = (v >= VA + VF && v < VA + VF + VSW) ? VP : ~VP;
    o.x = o.de ? 10'(h) : 10'd0;
    o.y = o.de ? 10'(v) : 10'd0;
    o.fs = (h == 0) && (v == 0);
    o.ls = (h == 0) && (v < VA);
    return o;
  endfunction

  task automatic cmp(input string nm, input out_t g, input out_t e);
    checks++;
    if (g !== e) begin
      failures++;
      $display("FAIL %s t=%0t got=%h exp=%h", nm, $time, g, e);
    end
  endtask

  task automatic chk(input string nm, input int g, input int e);
    checks++;
    if (g != e) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", nm, g, e);
    end
  endtask

  task automatic clr_stats();
    n_de = 0; n_white = 0; n_hs = 0; n_vs = 0;
    n_fs = 0; n_ls = 0; n_col = 0; n_bad = 0;
  endtask

  task automatic step(input logic ce);
    @(negedge clk);
    pix_ce = ce;
    if (ce && !rst) begin
      if (mh == 0 && mv == 0) begin
        sx0 = win_x0; sx1 = win_x1; sy0 = win_y0; sy1 = win_y1;
        sfg = fg_color; sbg = bg_color;
      end
      q.push_back(expect_px(mh, mv, sx0, sx1, sy0, sy1, sfg, sbg));
      mh++;
      if (mh == HT) begin
        mh = 0;
        mv++;
        if (mv == VT) mv = 0;
      end
    end
    @(posedge clk);
    #2;
  endtask

  task automatic assert_rst();
    rst = 1'b1;
    mh = 0; mv = 0;
    sx0 = '0; sx1 = '0; sy0 = '0; sy1 = '0;
    sfg = '0; sbg = '0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b1);
  endtask

  task automatic set_win(
    input int a, input int b, input int c, input int d,
    input logic [2:0] fg, input logic [2:0] bg
  );
    win_x0 = 10'(a); win_x1 = 10'(b);
    win_y0 = 10'(c); win_y1 = 10'(d);
    fg_color = fg; bg_color = bg;
  endtask

  always @(posedge rst) begin
    #1;
    cmp("rst_async", dut_out(), rst_val());
    last = rst_val();
  end

  always @(posedge clk) begin
    mon_ce = pix_ce;
    mon_rst = rst;
    #1;
    if (mon_rst) begin
      cmp("in_reset", dut_out(), rst_val());
    end else if (mon_ce) begin
      mon_g = dut_out();
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL no_expect t=%0t got=%h", $time, mon_g);
      end else begin
        mon_e = q.pop_front();
        cmp("pixel", mon_g, mon_e);
        last = mon_e;
      end
      n_de += int'(mon_g.de);
      n_white += int'(mon_g.c.r & mon_g.c.g & mon_g.c.b);
      n_hs += int'(mon_g.hs == HP);
      n_vs += int'(mon_g.vs == VP);
      n_fs += int'(mon_g.fs);
      n_ls += int'(mon_g.ls);
      n_col += int'(|mon_g.c);
      n_bad += int'((|mon_g.c) && !mon_g.de);
    end else begin
      cmp("hold", dut_out(), last);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    #1;
    assert_rst();
    for (int i = 0; i < 3; i++) step(1'b0);
    set_win(3, 13, 4, 8, 3'b111, 3'b000);
    rst = 1'b0;
    step(1'b0);

    clr_stats();
    run(FR);
    chk("a_de", n_de, 160);
    chk("a_white", n_white, 40);
    chk("a_hsync", n_hs, 51);
    chk("a_vsync", n_vs, 48);
    chk("a_fs", n_fs, 1);
    chk("a_ls", n_ls, 10);
    chk("a_blank_col", n_bad, 0);

    clr_stats();
    for (int i = 0; i < FR; i++) begin
      if (i == 6 * HT) win_x1 = 10'd5;
      step(1'b1);
    end
    chk("b_white_same", n_white, 40);

    clr_stats();
    run(FR);
    chk("c_white_new", n_white, 8);

    set_win(12, 5, 4, 8, 3'b111, 3'b010);
    clr_stats();
    run(FR);
    chk("d_white", n_white, 0);
    chk("d_col", n_col, 160);
    chk("d_blank_col", n_bad, 0);

    clr_stats();
    for (int i = 0; i < 2 * FR; i++) step((i % 2) == 0);
    chk("e_fs", n_fs, 1);
    chk("e_de", n_de, 160);
    chk("e_hsync", n_hs, 51);
    chk("e_col", n_col, 160);

    set_win(3, 13, 4, 8, 3'b111, 3'b000);
    run(5 * HT + 10);
    assert_rst();
    for (int i = 0; i < 3; i++) step(1'b1);
    rst = 1'b0;
    clr_stats();
    run(FR);
    chk("f_fs", n_fs, 1);
    chk("f_white", n_white, 40);
    chk("f_de", n_de, 160);
    chk("f_q_empty", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
